// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath and its capture buffer.
package fir_pkg;

  localparam int unsigned FIR_DOUT_W = 18;
  localparam int unsigned FIR_DIN_W  = 8;
  localparam int unsigned CAP_DEPTH  = 32;
  localparam int unsigned CAP_ADDR_W = 5;

  localparam logic [1:0] CAP_IDLE    = 2'd0;
  localparam logic [1:0] CAP_ARMED   = 2'd1;
  localparam logic [1:0] CAP_CAPTURE = 2'd2;
  localparam logic [1:0] CAP_DONE    = 2'd3;

  localparam logic TRIG_IMM     = 1'b0;
  localparam logic TRIG_NONZERO = 1'b1;

endpackage

// File: rtl/fir_capture_buf_if.sv
// Sample-in / control / read-back bundle of the FIR capture buffer.
interface fir_capture_buf_if #(
  parameter int unsigned DATA_W = fir_pkg::FIR_DOUT_W,
  parameter int unsigned ADDR_W = fir_pkg::CAP_ADDR_W
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              arm;
  logic              abort;
  logic              trig_mode;
  logic [ADDR_W:0]   cap_len;
  logic              rd_en;
  logic [ADDR_W:0]   rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic [ADDR_W:0]   cap_count;
  logic [DATA_W-1:0] peak_abs;

  modport slave (
    input  din, din_valid, arm, abort, trig_mode, cap_len, rd_en, rd_addr,
    output rd_data, rd_valid, busy, done, cap_count, peak_abs
  );

  modport master (
    output din, din_valid, arm, abort, trig_mode, cap_len, rd_en, rd_addr,
    input  rd_data, rd_valid, busy, done, cap_count, peak_abs
  );
endinterface

// File: rtl/cap_ram.sv
// Single-write, registered-read buffer; a same-cycle read of the written entry sees old data.
module cap_ram #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fir_capture_buf.sv
// Armed capture window over the FIR output stream with peak tracking and read-back port.
module fir_capture_buf
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W = FIR_DOUT_W,
  parameter int unsigned DEPTH  = CAP_DEPTH,
  parameter int unsigned ADDR_W = CAP_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  fir_capture_buf_if.slave  bus
);

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
  localparam logic [DATA_W-1:0] ABS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state_q, state_d;
  logic              trig_mode_q;
  logic [ADDR_W:0]   len_q, len_clamped;
  logic [ADDR_W:0]   cap_count_q, cap_count_d, cnt_inc;
  logic [DATA_W-1:0] peak_q, peak_d, din_abs;
  logic              done_q;
  logic              arm_ok, cfg_load, trig_hit;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              rd_valid_q, rd_oor_q;
  logic [DATA_W-1:0] ram_rd_data;

  // Saturating magnitude: the most negative code has no positive twin.
  always_comb begin
    din_abs = bus.din;
    if (bus.din == NEG_MIN)    din_abs = ABS_MAX;
    else if (bus.din[DATA_W-1]) din_abs = DATA_W'(-bus.din);
  end

  assign len_clamped = ((bus.cap_len == '0) || (bus.cap_len > DEPTH_L)) ? DEPTH_L : bus.cap_len;

  // Next state, write strobe, counters and peak; abort beats arm beats samples.
  always_comb begin
    state_d     = state_q;
    cap_count_d = cap_count_q;
    peak_d      = peak_q;
    wr_en       = 1'b0;
    wr_addr     = cap_count_q[ADDR_W-1:0];
    cnt_inc     = cap_count_q + ONE_L;
    arm_ok      = bus.arm && ((state_q == CAP_IDLE) || (state_q == CAP_DONE));
    cfg_load    = arm_ok && !bus.abort;
    trig_hit    = bus.din_valid &&
                  ((trig_mode_q == TRIG_IMM) ||
                   ((trig_mode_q == TRIG_NONZERO) && (bus.din != '0)));

    if (bus.abort) begin
      state_d = CAP_IDLE;
    end else if (arm_ok) begin
      state_d     = CAP_ARMED;
      cap_count_d = '0;
      peak_d      = '0;
    end else begin
      case (state_q)
        CAP_ARMED: begin
          if (trig_hit) begin
            wr_en       = 1'b1;
            wr_addr     = '0;
            cap_count_d = ONE_L;
            state_d     = (len_q == ONE_L) ? CAP_DONE : CAP_CAPTURE;
          end
        end
        CAP_CAPTURE: begin
          if (bus.din_valid) begin
            wr_en       = 1'b1;
            cap_count_d = cnt_inc;
            if (cnt_inc == len_q) state_d = CAP_DONE;
          end
        end
        default: ;
      endcase
      if (wr_en && (din_abs > peak_q)) peak_d = din_abs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= CAP_IDLE;
      cap_count_q <= '0;
      peak_q      <= '0;
      done_q      <= 1'b0;
      trig_mode_q <= TRIG_IMM;
      len_q       <= DEPTH_L;
    end else begin
      state_q     <= state_d;
      cap_count_q <= cap_count_d;
      peak_q      <= peak_d;
      done_q      <= (state_d == CAP_DONE);
      if (cfg_load) begin
        trig_mode_q <= bus.trig_mode;
        len_q       <= len_clamped;
      end
    end
  end

  // Read side: the out-of-range flag travels with the registered RAM output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= 1'b0;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) rd_oor_q <= (bus.rd_addr >= DEPTH_L);
    end
  end

  cap_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (reset_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (bus.din),
    .rd_en   (bus.rd_en),
    .rd_addr (bus.rd_addr[ADDR_W-1:0]),
    .rd_data (ram_rd_data)
  );

  assign bus.busy      = (state_q == CAP_ARMED) || (state_q == CAP_CAPTURE);
  assign bus.done      = done_q;
  assign bus.cap_count = cap_count_q;
  assign bus.peak_abs  = peak_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_oor_q ? '0 : ram_rd_data;

endmodule
